lsu_mem_port: RTL
=================

# lsu_mem_port

Load/store initiator that sits between the execute stage and the byte-addressed data memory. It converts RISC-V load/store requests into memory-port transactions. The memory port has one 32-bit word read, a combinational `RD`, and a word write on the clock edge. Byte and halfword stores are done as read-modify-write sequences. Loads are extracted and sign- or zero-extended. Misaligned and illegal requests are rejected without touching memory.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, word width (4 bytes)

Ports:
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `req_valid` input 1: request present
- `req_ready` output 1: block idle; the request is accepted on a clock edge where `req_valid` and `req_ready` are both 1
- `req_we` input 1: 1 = store, 0 = load
- `req_funct3` input 3: access type. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` input `ADDR_WIDTH`: byte address
- `req_wdata` input `DATA_WIDTH`: store data, low-aligned
- `resp_valid` output 1: one-cycle completion pulse
- `resp_rdata` output `DATA_WIDTH`: extended load data; 0 for stores and errors
- `resp_err` output 1: misaligned or illegal request, qualified by `resp_valid`
- `mem_A` output `ADDR_WIDTH`: memory byte address
- `mem_WE` output 1: memory write enable
- `mem_WD` output `DATA_WIDTH`: memory write word
- `mem_RD` input `DATA_WIDTH`: memory read word, combinational from `mem_A`

## Operation
- **Byte order:** big-endian. The byte at `mem_A` is `mem_RD[31:24]`. The halfword at `mem_A` is `mem_RD[31:16]`.
- **Request latch:** all request fields are latched at acceptance. Request inputs are ignored while `req_ready`=0.
- **Alignment check:** halfword accesses need `addr[0]`=0; word accesses need `addr[1:0]`=00.
- **Illegal encodings:**
  - load `funct3` 011, 110, 111
  - store `funct3` not in {000, 001, 010}
- **FSM states:** IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- **IDLE:**
  - Drives `req_ready`=1 and `mem_A`/`mem_WE`/`mem_WD` = 0.
  - On accept: error → RESP with `resp_err`=1; load → LOAD; SW → STORE; SB/SH → RMW_RD.
- **LOAD:**
  - Drives `mem_A`=addr, `mem_WE`=0.
  - At the edge, registers the extracted data and goes to RESP.
  - LB = sext(`RD[31:24]`), LBU = zext(`RD[31:24]`), LH = sext(`RD[31:16]`), LHU = zext(`RD[31:16]`), LW = `RD`.
- **STORE:** drives `mem_A`=addr, `mem_WE`=1, `mem_WD`=wdata, then goes to RESP.
- **RMW_RD:**
  - Drives `mem_A`=addr, `mem_WE`=0.
  - At the edge, registers the merged word and goes to RMW_WR.
  - SB merge: {`wdata[7:0]`, `RD[23:0]`}. SH merge: {`wdata[15:0]`, `RD[15:0]`}.
- **RMW_WR:** drives `mem_A`=addr, `mem_WE`=1, `mem_WD`=merged word, then goes to RESP.
- **RESP:** `resp_valid`=1 for exactly one cycle, `req_ready`=0, then goes to IDLE. There is no response backpressure.
- **Addresses:** `mem_A` is passed through unmodified. No wrap handling is done in this block.
- **Write limit:** `mem_WE` is asserted for at most one cycle per request and never on an error.

## Timing
- **Reset values:** `rst_n`=0 forces IDLE immediately (asynchronous). Outputs during reset: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_A`=0, `mem_WE`=0, `mem_WD`=0.
- **Latency, counted from the accept edge to the cycle with `resp_valid`=1:**
  - Error: next cycle.
  - Load or SW: 2nd cycle.
  - SB/SH: 3rd cycle.
- **Throughput:** the next request can be accepted in the cycle after RESP. `req_ready`=0 from the accept edge until IDLE is re-entered.
- **Register updates:** `resp_rdata` and `resp_err` are updated on entry to RESP. They hold their values until the next RESP.
- **Reset during an operation:** if `rst_n` falls during STORE or RMW_WR before the clock edge, no memory write occurs. After release, the block is in IDLE and the request is lost.
- **Read sampling:** `mem_RD` is sampled only at the end of LOAD and RMW_RD. Its value in any other cycle is ignored.

## Test plan
1. **Loads:** preload bytes 0x100..0x103 = 80 12 34 56.
   - LW 0x100 → `resp_rdata`=0x80123456, `resp_valid` in the 2nd cycle after accept.
   - LB → 0xFFFFFF80. LBU → 0x00000080. LH → 0xFFFF8012. LHU → 0x00008012.
2. **SB read-modify-write:** SB 0x100, wdata 0xAABBCCDD, on the same preload → memory bytes become DD 12 34 56. `mem_WE` is high exactly one cycle (RMW_WR). `resp_valid` in the 3rd cycle. `resp_rdata`=0.
3. **SH then SW:**
   - SH 0x200, wdata 0x0000BEEF, over bytes 11 22 33 44 → bytes become BE EF 33 44.
   - SW 0x204, wdata 0xCAFEF00D, then LW 0x204 → 0xCAFEF00D.
4. **Errors:**
   - LH 0x101, SW 0x202, and load `funct3`=011 → `resp_err`=1 and `resp_rdata`=0 in the next cycle.
   - `mem_WE` is never asserted and memory is unchanged.
5. **Back-to-back requests:** hold `req_valid`=1 with an LW then an SB queued.
   - `req_ready` stays low through LOAD and RESP.
   - The SB is accepted on the edge after RESP; no request is dropped or duplicated.
6. **Reset during write:** pulse `rst_n` low mid-cycle in RMW_WR of SB 0x300 → bytes at 0x300 are unchanged. All outputs are at their reset values. `req_ready`=1 after release.

Source files
------------

// File: rtl/lsu_mem_port_if.sv
// Bundle of the request, response and memory-port signals of lsu_mem_port.
// The slave side is the load/store unit itself. The master side is the
// environment: the execute stage drives requests and the data memory returns
// the combinational read word.
interface lsu_mem_port_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic [ADDR_WIDTH-1:0] mem_A;
  logic                  mem_WE;
  logic [DATA_WIDTH-1:0] mem_WD;
  logic [DATA_WIDTH-1:0] mem_RD;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_A, mem_WE, mem_WD
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_A, mem_WE, mem_WD
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store initiator between the execute stage and a big-endian,
// byte-addressed data memory. The memory port returns one 32-bit word
// combinationally and writes one word on the clock edge. Sub-word stores are
// done as read-modify-write. Misaligned or illegal requests complete with an
// error and never reach memory.
module lsu_mem_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_mem_port_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            f3_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] merged_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  req_ready;
  logic                  resp_valid;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  accept;
  logic                  req_bad;

  // Extract the addressed byte/halfword from the top of the big-endian word.
  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [2:0]            f3,
    input logic [DATA_WIDTH-1:0] rd
  );
    case (f3)
      3'b000:  return {{24{rd[31]}}, rd[31:24]};
      3'b001:  return {{16{rd[31]}}, rd[31:16]};
      3'b100:  return {24'd0, rd[31:24]};
      3'b101:  return {16'd0, rd[31:16]};
      default: return rd;
    endcase
  endfunction

  // Insert the store byte/halfword at the top of the word and keep the rest.
  function automatic logic [DATA_WIDTH-1:0] rmw_merge(
    input logic        half,
    input logic [15:0] wd,
    input logic [23:0] rd_lo
  );
    if (half) return {wd, rd_lo[15:0]};
    return {wd[7:0], rd_lo};
  endfunction

  // An illegal encoding or a misaligned halfword/word address is an error.
  function automatic logic req_error(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic illegal;
    logic misaligned;
    if (we) illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
    else    illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    misaligned = ((f3[1:0] == 2'b01) && a[0]) ||
                 ((f3[1:0] == 2'b10) && (a != 2'b00));
    return illegal || misaligned;
  endfunction

  assign accept  = (state == IDLE) && bus.req_valid;
  assign req_bad = req_error(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  // State register; reset returns to IDLE at once, which drops mem_WE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and the memory/handshake outputs, decoded from the state.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_a      = '0;
    mem_we     = 1'b0;
    mem_wd     = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_bad)          state_nxt = RESP;
          else if (!bus.req_we) state_nxt = LOAD;
          else if (bus.req_funct3[1]) state_nxt = STORE;
          else                  state_nxt = RMW_RD;
        end
      end
      LOAD: begin
        mem_a     = addr_q;
        state_nxt = RESP;
      end
      STORE: begin
        mem_a     = addr_q;
        mem_we    = 1'b1;
        mem_wd    = wdata_q;
        state_nxt = RESP;
      end
      RMW_RD: begin
        mem_a     = addr_q;
        state_nxt = RMW_WR;
      end
      RMW_WR: begin
        mem_a     = addr_q;
        mem_we    = 1'b1;
        mem_wd    = merged_q;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response registers, written only on the transition into RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept && req_bad) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end else if (state == LOAD) begin
        rdata_q <= load_extract(f3_q, bus.mem_RD);
        err_q   <= 1'b0;
      end else if (state == STORE || state == RMW_WR) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  // Request latch at acceptance and the merged word captured in RMW_RD.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.req_addr;
      f3_q    <= bus.req_funct3;
      wdata_q <= bus.req_wdata;
    end
    if (state == RMW_RD)
      merged_q <= rmw_merge(f3_q[0], wdata_q[15:0], bus.mem_RD[23:0]);
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_A      = mem_a;
  assign bus.mem_WE     = mem_we;
  assign bus.mem_WD     = mem_wd;

endmodule
